// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path.
//   rxf_state_t : handshake FSM states of rx_fifo
//   UART_DATA_W : width of one received character
//   ERR_CNT_W   : width of the saturating parity-error counter
package uart_pkg;

  typedef enum logic {WAIT_RX, HOLD} rxf_state_t;

  localparam int UART_DATA_W = 8;
  localparam int ERR_CNT_W   = 8;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a show-ahead read port.
//   clk, Reset   : clock, synchronous active-high reset (pointers/count only)
//   wrEn_i       : request to write wrData_i
//   wrData_i     : write data
//   wrAccept_o   : the write is taken this cycle (not full, or a pop frees a slot)
//   rdReady_i    : consumer pops the head when rdValid_o=1
//   rdValid_o    : FIFO not empty
//   rdData_o     : head entry, forced to 0 when empty
//   count_o      : entries stored, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             wrEn_i,
  input  logic [WIDTH-1:0] wrData_i,
  output logic             wrAccept_o,
  input  logic             rdReady_i,
  output logic             rdValid_o,
  output logic [WIDTH-1:0] rdData_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] memQ [DEPTH];
  logic [PTR_W-1:0] wrPtrQ, wrPtrD;
  logic [PTR_W-1:0] rdPtrQ, rdPtrD;
  logic [CNT_W-1:0] countQ, countD;
  logic             full;
  logic             empty;
  logic             pop;

  assign full  = (countQ == CNT_W'(DEPTH));
  assign empty = (countQ == '0);
  assign pop   = rdReady_i & ~empty;

  // A full FIFO can still accept when the head leaves in the same cycle.
  assign wrAccept_o = wrEn_i & (~full | pop);

  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    if (wrAccept_o) wrPtrD = wrPtrQ + 1'b1;
    if (pop)        rdPtrD = rdPtrQ + 1'b1;
    if (wrAccept_o && !pop)      countD = countQ + 1'b1;
    else if (!wrAccept_o && pop) countD = countQ - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wrAccept_o) memQ[wrPtrQ] <= wrData_i;
  end

  assign rdValid_o = ~empty;
  assign rdData_o  = empty ? '0 : memQ[rdPtrQ];
  assign count_o   = countQ;

endmodule

// File: rtl/rx_fifo.sv
// rx_fifo
// Receive-side buffer behind the UART receiver. Completes the four-phase
// Receive/Received handshake, stores {parityErr, data} in a FIFO and offers
// it through a show-ahead valid/ready port.
//   clk, Reset            : clock, synchronous active-high reset
//   Receive, rxData,
//   rxParityErr           : byte offered by the receiver (level, held)
//   Received              : registered acknowledge back to the receiver
//   rdValid, rdData,
//   rdErr, rdReady        : consumer read port (0 data when empty)
//   count                 : entries stored
//   overflow, clrOverflow : sticky drop flag and its clear
//   errCount              : saturating count of accepted bytes with parity error
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   Receive,
  input  logic [UART_DATA_W-1:0] rxData,
  input  logic                   rxParityErr,
  output logic                   Received,
  output logic                   rdValid,
  output logic [UART_DATA_W-1:0] rdData,
  output logic                   rdErr,
  input  logic                   rdReady,
  output logic [CNT_W-1:0]       count,
  output logic                   overflow,
  input  logic                   clrOverflow,
  output logic [ERR_CNT_W-1:0]   errCount
);

  rxf_state_t             stateQ, stateD;
  logic                   receivedQ, receivedD;
  logic                   overflowQ, overflowD;
  logic [ERR_CNT_W-1:0]   errCountQ, errCountD;
  logic                   wrEn;
  logic                   wrAccept;
  logic                   drop;
  logic [UART_DATA_W:0]   headEntry;

  sync_fifo #(
    .WIDTH (UART_DATA_W + 1),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .Reset      (Reset),
    .wrEn_i     (wrEn),
    .wrData_i   ({rxParityErr, rxData}),
    .wrAccept_o (wrAccept),
    .rdReady_i  (rdReady),
    .rdValid_o  (rdValid),
    .rdData_o   (headEntry),
    .count_o    (count)
  );

  // Capture only on the WAIT_RX edge; Receive still high while in HOLD is
  // the same byte and must not be written again.
  always_comb begin
    stateD    = stateQ;
    receivedD = receivedQ;
    wrEn      = 1'b0;
    case (stateQ)
      WAIT_RX: begin
        if (Receive) begin
          wrEn      = 1'b1;
          receivedD = 1'b1;
          stateD    = HOLD;
        end
      end
      HOLD: begin
        if (!Receive) begin
          receivedD = 1'b0;
          stateD    = WAIT_RX;
        end
      end
      default: begin
        receivedD = 1'b0;
        stateD    = WAIT_RX;
      end
    endcase
  end

  // A dropped byte still completes the handshake so the receiver never stalls.
  assign drop = wrEn & ~wrAccept;

  always_comb begin
    overflowD = overflowQ;
    errCountD = errCountQ;
    if (drop)             overflowD = 1'b1;
    else if (clrOverflow) overflowD = 1'b0;
    if (wrAccept && rxParityErr && (errCountQ != '1))
      errCountD = errCountQ + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      stateQ    <= WAIT_RX;
      receivedQ <= 1'b0;
      overflowQ <= 1'b0;
      errCountQ <= '0;
    end else begin
      stateQ    <= stateD;
      receivedQ <= receivedD;
      overflowQ <= overflowD;
      errCountQ <= errCountD;
    end
  end

  assign Received = receivedQ;
  assign overflow = overflowQ;
  assign errCount = errCountQ;
  assign rdData   = headEntry[UART_DATA_W-1:0];
  assign rdErr    = headEntry[UART_DATA_W];

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo
// Drives rx_fifo from a model of the UART receiver handshake and a consumer.
// Every byte the receiver offers is judged accepted or dropped by the bench's
// own occupancy model; accepted bytes go into a scoreboard queue that is
// compared against the read port as the consumer pops.
module tb_rx_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             Reset;
  logic             Receive;
  logic [7:0]       rxData;
  logic             rxParityErr;
  logic             Received;
  logic             rdValid;
  logic [7:0]       rdData;
  logic             rdErr;
  logic             rdReady;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             clrOverflow;
  logic [7:0]       errCount;

  int errors = 0;
  int checks = 0;

  logic [8:0] sbQueue[$];
  int         modelCount = 0;
  int         modelErr   = 0;
  logic       modelOvf   = 1'b0;

  rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .Receive     (Receive),
    .rxData      (rxData),
    .rxParityErr (rxParityErr),
    .Received    (Received),
    .rdValid     (rdValid),
    .rdData      (rdData),
    .rdErr       (rdErr),
    .rdReady     (rdReady),
    .count       (count),
    .overflow    (overflow),
    .clrOverflow (clrOverflow),
    .errCount    (errCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compare the head of the read port against the scoreboard.
  task automatic checkHead();
    logic [8:0] head;
    checkOutput("headValid", rdValid, 1);
    if (sbQueue.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL sbUnderflow: got pop with empty scoreboard, expected entry");
    end else begin
      head = sbQueue.pop_front();
      checkOutput("headData", rdData, head[7:0]);
      checkOutput("headErr", rdErr, head[8]);
    end
  endtask

  // Receiver model: one complete handshake starting just after a negedge.
  // Optionally pops in the same cycle as the capture.
  task automatic applyStimulus(input logic [7:0] data, input logic err,
                               input logic doPop);
    logic accepted;
    Receive     = 1'b1;
    rxData      = data;
    rxParityErr = err;
    if (doPop) begin
      checkHead();
      rdReady = 1'b1;
    end
    accepted = (modelCount < DEPTH) || doPop;
    if (accepted) begin
      sbQueue.push_back({err, data});
      if (err && modelErr < 255) modelErr++;
      modelCount = modelCount + 1 - (doPop ? 1 : 0);
    end else begin
      modelOvf = 1'b1;
    end
    @(negedge clk);
    rdReady = 1'b0;
    checkOutput("receivedHigh", Received, 1);
    checkOutput("countAfterWr", count, modelCount);
    checkOutput("overflow", overflow, modelOvf);
    checkOutput("errCount", errCount, modelErr);
    @(negedge clk);
    Receive     = 1'b0;
    rxData      = 8'h00;
    rxParityErr = 1'b0;
    @(negedge clk);
    checkOutput("receivedLow", Received, 0);
    @(negedge clk);
  endtask

  // Consumer model: pop one entry and check it.
  task automatic drainOne();
    checkHead();
    rdReady = 1'b1;
    @(negedge clk);
    rdReady = 1'b0;
    modelCount--;
    checkOutput("countAfterPop", count, modelCount);
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, "Valid"}, rdValid, 0);
    checkOutput({tag, "Data"}, rdData, 0);
    checkOutput({tag, "Err"}, rdErr, 0);
    checkOutput({tag, "Count"}, count, 0);
  endtask

  task automatic pulseClearOverflow();
    clrOverflow = 1'b1;
    @(negedge clk);
    clrOverflow = 1'b0;
    modelOvf = 1'b0;
    checkOutput("ovfCleared", overflow, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    Reset       = 1'b1;
    Receive     = 1'b0;
    rxData      = 8'h00;
    rxParityErr = 1'b0;
    rdReady     = 1'b0;
    clrOverflow = 1'b0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;

    // Reset state.
    checkEmpty("reset");
    checkOutput("resetReceived", Received, 0);
    checkOutput("resetOvf", overflow, 0);
    checkOutput("resetErrCnt", errCount, 0);

    // Single byte.
    applyStimulus(8'hA5, 1'b0, 1'b0);
    checkOutput("singleCount", count, 1);
    drainOne();
    checkEmpty("afterSingle");

    // Ordering and parity errors.
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    checkOutput("errCountOne", errCount, 1);
    repeat (3) drainOne();
    checkEmpty("afterOrder");

    // Full FIFO: 17 bytes, the last one is dropped.
    for (int i = 0; i <= 16; i++) applyStimulus(8'(i), 1'b0, 1'b0);
    checkOutput("fullCount", count, 16);
    checkOutput("fullOvf", overflow, 1);
    for (int i = 0; i < 16; i++) drainOne();
    checkEmpty("afterFull");
    pulseClearOverflow();

    // Simultaneous capture and pop while full.
    for (int i = 0; i < 16; i++) applyStimulus(8'h20 + 8'(i), 1'b0, 1'b0);
    applyStimulus(8'h55, 1'b0, 1'b1);
    checkOutput("pushPopCount", count, 16);
    checkOutput("pushPopOvf", overflow, 0);
    for (int i = 0; i < 16; i++) drainOne();
    checkEmpty("afterPushPop");

    // Wrap-around: one byte in, one byte out, 40 times.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'h80 + 8'(i), logic'(i % 7 == 0), 1'b0);
      checkOutput("wrapCountMax", (count <= 1) ? 1 : 0, 1);
      drainOne();
    end
    checkEmpty("afterWrap");

    // Reset mid-handshake.
    Receive     = 1'b1;
    rxData      = 8'hC3;
    rxParityErr = 1'b1;
    @(negedge clk);
    checkOutput("holdReceived", Received, 1);
    Reset   = 1'b1;
    Receive = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    sbQueue.delete();
    modelCount = 0;
    modelErr   = 0;
    modelOvf   = 1'b0;
    checkOutput("midResetReceived", Received, 0);
    checkOutput("midResetOvf", overflow, 0);
    checkOutput("midResetErrCnt", errCount, 0);
    checkEmpty("midReset");
    applyStimulus(8'h3C, 1'b0, 1'b0);
    drainOne();
    checkEmpty("afterResetByte");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
